dotp_job_scheduler: RTL and testbench

- Shares the dot-product datapath (vector reader, MAC, result writer into the result memory) between two requesters.
- Arbitrates round-robin and issues a one-cycle start pulse carrying the result slot address.
- Waits for reading-done, then writer-done, guarded by a watchdog, and reports completion per job.
- Sits between software-facing request ports and the dot-product top level's start_reading / reading_done / writer_busy / writer_done signals.

---
 rtl/dotp_job_scheduler.sv | 132 +++++++++++++
 tb/tb_dotp_job_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotp_job_scheduler.sv
// Two-requester round-robin front end for the shared dot-product datapath:
// grants a job, pulses start, tracks reader/writer completion under a watchdog.
module dotp_job_scheduler #(
  parameter int MEM3_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int TMO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [MEM3_ADDR_WIDTH-1:0] req0_slot,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [MEM3_ADDR_WIDTH-1:0] req1_slot,
  output logic                       req1_ready,
  output logic                       dp_start,
  output logic [MEM3_ADDR_WIDTH-1:0] dp_result_addr,
  input  logic                       dp_reading_done,
  input  logic                       dp_writer_busy,
  input  logic                       dp_writer_done,
  output logic                       done_valid,
  output logic                       done_id,
  output logic [MEM3_ADDR_WIDTH-1:0] done_slot,
  output logic                       done_timeout,
  output logic                       busy
);

  localparam int WD_W = (TMO_WIDTH < 1) ? 1 : TMO_WIDTH;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {IDLE, START, WAIT_READ, WAIT_WRITE, DONE} state_t;

  state_t            state;
  logic              last_grant;
  logic              job_id;
  logic [WD_W-1:0]   wd;
  logic              can_grant;
  logic              grant0;
  logic              grant1;
  logic              wd_expired;
  logic              finish;
  logic              finish_tmo;

  // On a tie the requester that did not own the previous job wins.
  always_comb begin
    can_grant  = rst_n && (state == IDLE) && !dp_writer_busy;
    grant0     = can_grant && req0_valid && (!req1_valid || last_grant);
    grant1     = can_grant && req1_valid && (!req0_valid || !last_grant);
    wd_expired = WD_EN && (wd == WD_LAST);
    finish     = 1'b0;
    finish_tmo = 1'b0;
    case (state)
      WAIT_READ: begin
        if (dp_reading_done && dp_writer_done) begin
          finish = 1'b1;
        end else if (!dp_reading_done && wd_expired) begin
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end
      end
      WAIT_WRITE: begin
        if (dp_writer_done) begin
          finish = 1'b1;
        end else if (wd_expired) begin
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      job_id         <= 1'b0;
      wd             <= '0;
      dp_start       <= 1'b0;
      dp_result_addr <= '0;
      done_valid     <= 1'b0;
      done_id        <= 1'b0;
      done_slot      <= '0;
      done_timeout   <= 1'b0;
    end else begin
      dp_start   <= 1'b0;
      done_valid <= 1'b0;
      if (finish) begin
        state        <= DONE;
        done_valid   <= 1'b1;
        done_id      <= job_id;
        done_slot    <= dp_result_addr;
        done_timeout <= finish_tmo;
      end else begin
        case (state)
          IDLE: begin
            if (grant0 || grant1) begin
              job_id         <= grant1;
              dp_result_addr <= grant1 ? req1_slot : req0_slot;
              dp_start       <= 1'b1;
              state          <= START;
            end
          end
          START: begin
            wd    <= '0;
            state <= WAIT_READ;
          end
          WAIT_READ: begin
            if (dp_reading_done) begin
              wd    <= '0;
              state <= WAIT_WRITE;
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
          WAIT_WRITE: wd <= wd + WD_W'(1);
          DONE: begin
            last_grant <= job_id;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dotp_job_scheduler.sv
// Scenario bench for dotp_job_scheduler: a completion monitor pops expected
// jobs from a scoreboard queue; each task checks its own cycle-level timing.
module tb_dotp_job_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_slot = '0, req1_slot = '0;
  logic       req0_ready, req1_ready;
  logic       dp_start;
  logic [3:0] dp_result_addr;
  logic       dp_reading_done = 1'b0, dp_writer_busy = 1'b0, dp_writer_done = 1'b0;
  logic       done_valid, done_id, done_timeout, busy;
  logic [3:0] done_slot;

  logic [5:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dotp_job_scheduler #(.MEM3_ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_slot(req0_slot), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_slot(req1_slot), .req1_ready(req1_ready),
    .dp_start(dp_start), .dp_result_addr(dp_result_addr),
    .dp_reading_done(dp_reading_done), .dp_writer_busy(dp_writer_busy),
    .dp_writer_done(dp_writer_done),
    .done_valid(done_valid), .done_id(done_id), .done_slot(done_slot),
    .done_timeout(done_timeout), .busy(busy)
  );

  // Completion monitor: every done pulse must match the oldest expected job.
  always @(posedge clk) begin
    logic [5:0] e;
    #2;
    n_checks++;
    if (req0_ready && req1_ready) begin
      n_fail++;
      $display("FAIL two_ready: got req0_ready=1 req1_ready=1, required at most one");
    end
    if (done_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got id=%0d slot=%0d tmo=%0d, required no completion",
                 done_id, done_slot, done_timeout);
      end else begin
        e = sb.pop_front();
        if ({done_id, done_slot, done_timeout} !== e) begin
          n_fail++;
          $display("FAIL done_fields: got id=%0d slot=%0d tmo=%0d, required id=%0d slot=%0d tmo=%0d",
                   done_id, done_slot, done_timeout, e[5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_slot = 4'd3;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, dp_start, dp_result_addr, done_valid, done_id, done_slot,
         done_timeout, busy} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got r0=%0d r1=%0d st=%0d addr=%0d dv=%0d id=%0d slot=%0d to=%0d busy=%0d, required all 0",
               req0_ready, req1_ready, dp_start, dp_result_addr, done_valid, done_id, done_slot, done_timeout, busy);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%0d r0=%0d, required 0 0", busy, req0_ready);
    end
  endtask

  task automatic test_single_job();
    @(negedge clk);
    req0_valid = 1'b1; req0_slot = 4'd3;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: got r0=%0d r1=%0d, required 1 0", req0_ready, req1_ready);
    end
    sb.push_back({1'b0, 4'd3, 1'b0});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      dp_reading_done = (k == 5);
      dp_writer_done = (k == 8);
      n_checks++;
      if (dp_start !== (k == 1) || busy !== (k <= 9) || done_valid !== (k == 9)) begin
        n_fail++;
        $display("FAIL single_timing k=%0d: got start=%0d busy=%0d dv=%0d, required %0d %0d %0d",
                 k, dp_start, busy, done_valid, (k == 1), (k <= 9), (k == 9));
      end
      if (k == 1) begin
        n_checks++;
        if (dp_result_addr !== 4'd3) begin
          n_fail++;
          $display("FAIL single_addr: got %0d, required 3", dp_result_addr);
        end
      end
    end
    dp_reading_done = 1'b0; dp_writer_done = 1'b0;
  endtask

  task automatic test_fairness();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_slot = 4'd5;
    req1_valid = 1'b1; req1_slot = 4'd9;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      int w;
      logic exp_id;
      exp_id = j[0];
      w = 0;
      #1;
      while (!(req0_ready || req1_ready) && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      n_checks++;
      if (req1_ready !== exp_id || req0_ready !== !exp_id) begin
        n_fail++;
        $display("FAIL fair_grant j=%0d: got r0=%0d r1=%0d, required grant to %0d",
                 j, req0_ready, req1_ready, exp_id);
      end
      sb.push_back({exp_id, exp_id ? 4'd9 : 4'd5, 1'b0});
      @(negedge clk);
      n_checks++;
      if (dp_start !== 1'b1 || dp_result_addr !== (exp_id ? 4'd9 : 4'd5)) begin
        n_fail++;
        $display("FAIL fair_start j=%0d: got start=%0d addr=%0d, required 1 %0d",
                 j, dp_start, dp_result_addr, exp_id ? 9 : 5);
      end
      @(negedge clk);
      dp_reading_done = 1'b1; dp_writer_done = 1'b1;
      @(negedge clk);
      dp_reading_done = 1'b0; dp_writer_done = 1'b0;
      if (j == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    req1_valid = 1'b1; req1_slot = 4'd7;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_grant: got r1=%0d, required 1", req1_ready);
    end
    sb.push_back({1'b1, 4'd7, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      req0_valid = 1'b0;
      dp_reading_done = (k == 2 || k == 6);
      dp_writer_done = (k == 2 || k == 6);
      n_checks++;
      if (done_valid !== (k == 3 || k == 7)) begin
        n_fail++;
        $display("FAIL same_done k=%0d: got dv=%0d, required %0d", k, done_valid, (k == 3 || k == 7));
      end
      if (k == 4) begin
        req0_valid = 1'b1; req0_slot = 4'd2;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL same_rearm: got r0=%0d, required 1", req0_ready);
        end
        sb.push_back({1'b0, 4'd2, 1'b0});
      end
    end
    dp_reading_done = 1'b0; dp_writer_done = 1'b0;
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    req0_valid = 1'b1; req0_slot = 4'd4;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_grant: got r0=%0d, required 1", req0_ready);
    end
    sb.push_back({1'b0, 4'd4, 1'b1});
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      n_checks++;
      if (done_valid !== (k == 18) || (k == 18 && done_timeout !== 1'b1)) begin
        n_fail++;
        $display("FAIL wd_timing k=%0d: got dv=%0d to=%0d, required dv=%0d to=1",
                 k, done_valid, done_timeout, (k == 18));
      end
    end
    req1_valid = 1'b1; req1_slot = 4'd6;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_next_grant: got r1=%0d, required 1", req1_ready);
    end
    sb.push_back({1'b1, 4'd6, 1'b0});
    for (int m = 1; m <= 6; m++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      dp_reading_done = (m == 3);
      dp_writer_done = (m == 5);
      n_checks++;
      if (done_valid !== (m == 6) || (m == 6 && done_timeout !== 1'b0)) begin
        n_fail++;
        $display("FAIL wd_next_done m=%0d: got dv=%0d to=%0d, required dv=%0d to=0",
                 m, done_valid, done_timeout, (m == 6));
      end
    end
    dp_reading_done = 1'b0; dp_writer_done = 1'b0;
  endtask

  task automatic test_writer_busy();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      dp_writer_busy = 1'b1;
      req1_valid = 1'b1; req1_slot = 4'd11;
      #1;
      n_checks++;
      if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_hold k=%0d: got r1=%0d r0=%0d, required 0 0", k, req1_ready, req0_ready);
      end
    end
    @(negedge clk);
    dp_writer_busy = 1'b0;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_release: got r1=%0d, required 1", req1_ready);
    end
    sb.push_back({1'b1, 4'd11, 1'b0});
    @(negedge clk);
    req1_valid = 1'b0;
    n_checks++;
    if (dp_start !== 1'b1 || dp_result_addr !== 4'd11) begin
      n_fail++;
      $display("FAIL wb_start: got start=%0d addr=%0d, required 1 11", dp_start, dp_result_addr);
    end
    @(negedge clk);
    dp_writer_busy = 1'b1;
    dp_reading_done = 1'b1; dp_writer_done = 1'b1;
    @(negedge clk);
    dp_writer_busy = 1'b0;
    dp_reading_done = 1'b0; dp_writer_done = 1'b0;
    n_checks++;
    if (done_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_done: got dv=%0d, required 1", done_valid);
    end
  endtask

  task automatic test_reset_mid_job();
    @(negedge clk);
    req0_valid = 1'b1; req0_slot = 4'd1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmj_grant: got r0=%0d, required 1", req0_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      dp_reading_done = (k == 2 || k == 7);
      dp_writer_done = (k >= 4 && k <= 7);
      if (k == 3) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL rmj_busy: got busy=%0d, required 1", busy);
        end
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_slot = 4'd12;
      end
      if (k == 4) begin
        rst_n = 1'b1;
        req0_valid = 1'b1;
        #1;
        n_checks++;
        if ({dp_start, dp_result_addr, done_valid, done_id, done_slot, done_timeout, busy} !== 14'h0) begin
          n_fail++;
          $display("FAIL rmj_cleared: got st=%0d addr=%0d dv=%0d id=%0d slot=%0d to=%0d busy=%0d, required all 0",
                   dp_start, dp_result_addr, done_valid, done_id, done_slot, done_timeout, busy);
        end
        n_checks++;
        if (req0_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rmj_regrant: got r0=%0d, required 1", req0_ready);
        end
        sb.push_back({1'b0, 4'd12, 1'b0});
      end
      if (k == 5) begin
        n_checks++;
        if (dp_start !== 1'b1 || dp_result_addr !== 4'd12) begin
          n_fail++;
          $display("FAIL rmj_start: got start=%0d addr=%0d, required 1 12", dp_start, dp_result_addr);
        end
      end
      n_checks++;
      if (done_valid !== (k == 8)) begin
        n_fail++;
        $display("FAIL rmj_done k=%0d: got dv=%0d, required %0d", k, done_valid, (k == 8));
      end
    end
    dp_reading_done = 1'b0; dp_writer_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fairness();
    test_same_cycle();
    test_watchdog();
    test_writer_busy();
    test_reset_mid_job();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
